// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath blocks.
package mips_pkg;
  localparam int DATA_W = 32;
endpackage

// File: rtl/mux_2x1.sv
// One-bit 2:1 select cell in and/or form.
// Latency: none. Backpressure: none.
module mux_2x1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic out
);
  logic s_n;
  logic pick_a;
  logic pick_b;
  logic agree;

  assign s_n    = ~s;
  assign pick_a = a & s_n;
  assign pick_b = b & s;
  // Consensus term: keeps the output defined when s is X but a and b agree.
  assign agree  = a & b;
  assign out    = pick_a | pick_b | agree;
endmodule

// File: rtl/mux_32x1.sv
// Word-wide 2:1 selector with a combinational output and a registered copy.
// Latency: result 0 cycles, result_q 1 cycle. Backpressure: none.
module mux_32x1
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s0,
  output logic [WIDTH-1:0] result_q
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2x1 u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .s   (s0),
      .out (result[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) result_q <= '0;
    else     result_q <= result;
  end
endmodule

// File: tb/tb_mux_32x1.sv
// Directed and random checks of mux_32x1 against a select-rule model.
module tb_mux_32x1;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         s0;
  logic [W-1:0] result;
  logic [W-1:0] result_q;
  logic [W-1:0] q_model;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_32x1 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .result   (result),
    .a        (a),
    .b        (b),
    .s0       (s0),
    .result_q (result_q)
  );

  function automatic logic [W-1:0] sel(input logic [W-1:0] wa, input logic [W-1:0] wb,
                                       input logic ws);
    return ws ? wb : wa;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, check result, then check result_q after the rising edge.
  task automatic apply(input string tag, input logic [W-1:0] na, input logic [W-1:0] nb,
                       input logic ns, input logic nr);
    @(negedge clk);
    a = na; b = nb; s0 = ns; rst = nr;
    #1 check({tag, "_comb"}, result, sel(na, nb, ns));
    q_model = nr ? '0 : sel(na, nb, ns);
    @(posedge clk);
    #1 check({tag, "_reg"}, result_q, q_model);
  endtask

  initial begin
    rst = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; s0 = 1'b0;
    @(posedge clk);
    #1 check("reset_q", result_q, '0);

    apply("t1", 32'd0, 32'd127, 1'b1, 1'b0);
    apply("t2", 32'd0, 32'd127, 1'b0, 1'b0);

    // Selection change with no clock edge in between.
    @(negedge clk);
    a = 32'd16914; b = 32'd127; s0 = 1'b0;
    #1 check("t3_a", result, 32'd16914);
    s0 = 1'b1;
    #1 check("t3_b", result, 32'd127);
    @(posedge clk);
    #1 check("t3_reg", result_q, 32'd127);

    for (int i = 0; i < 6; i++)
      apply("t4_alt", 32'hFFFF_FFFF, 32'h0000_0000, i[0], 1'b0);

    apply("t5_rst", 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
    apply("t5_rel", 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);

    apply("t6_a", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    apply("t6_b", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);

    for (int i = 0; i < 200; i++)
      apply("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
